// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register dump block: FSM encoding and record layout.
package regfile_dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_FIN
    } state_t;

    // Width of the per-record tag byte that carries the register index.
    localparam int unsigned TAG_W = 8;

    // Bytes per record: one tag byte followed by the data word, MSB byte first.
    function automatic int unsigned rec_bytes(input int unsigned data_w);
        return (TAG_W + data_w) / 8;
    endfunction

    localparam int unsigned BYTES_PER_REC = rec_bytes(32);

endpackage

// File: rtl/regfile_dump_if.sv
// Byte stream toward the CLI transmitter (valid/ready handshake).
interface regfile_dump_if;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;

    modport master (
        output TX_DATA,
        output TX_VALID,
        input  TX_READY
    );

    modport slave (
        input  TX_DATA,
        input  TX_VALID,
        output TX_READY
    );
endinterface

// File: rtl/regfile_dump_word_byte_serializer.sv
// Loads a {tag, word} record and shifts it out one byte per accepted transfer.
module word_byte_serializer
    import regfile_dump_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NBYTES = BYTES_PER_REC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [TAG_W-1:0]    tag,
    input  logic [DATA_W-1:0]   word,
    regfile_dump_if.master      tx,
    output logic                last_acc
);

    localparam int unsigned REC_W = TAG_W + DATA_W;
    localparam int unsigned CNT_W = $clog2(NBYTES);

    logic [REC_W-1:0] rec;
    logic [CNT_W-1:0] cnt;
    logic             active;
    logic             xfer;

    // Handshake decode; TX_VALID comes straight from a flop, never from TX_READY.
    always_comb begin
        xfer        = active & tx.TX_READY;
        last_acc    = xfer && (cnt == CNT_W'(NBYTES - 1));
        tx.TX_VALID = active;
        tx.TX_DATA  = active ? rec[REC_W-1 -: 8] : '0;
    end

    // Record register: capture on load, shift left one byte per transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rec    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            rec    <= {tag, word};
            cnt    <= '0;
            active <= 1'b1;
        end else if (xfer) begin
            rec <= {rec[REC_W-9:0], 8'h00};
            cnt <= cnt + 1'b1;
            if (last_acc) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_dump.sv
// Walks register addresses through read port 1 and streams tagged records to the CLI.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] A1,
    input  logic [DATA_W-1:0] RD1,
    regfile_dump_if.master    tx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic              load;
    logic              last_acc;

    // State and index registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state, read address and status outputs.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        A1        = idx;
        case (state)
            ST_IDLE: begin
                A1 = '0;
                if (START) begin
                    state_nxt = ST_LOAD;
                    idx_nxt   = '0;
                end
            end
            ST_LOAD: begin
                BUSY      = 1'b1;
                load      = 1'b1;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                BUSY = 1'b1;
                if (last_acc) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_FIN;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_FIN: begin
                BUSY      = 1'b1;
                DONE      = 1'b1;
                idx_nxt   = '0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    word_byte_serializer #(
        .DATA_W (DATA_W),
        .NBYTES (rec_bytes(DATA_W))
    ) u_ser (
        .clk      (CLK),
        .rst      (RST),
        .load     (load),
        .tag      (TAG_W'(idx)),
        .word     (RD1),
        .tx       (tx),
        .last_acc (last_acc)
    );

endmodule
